multiply: RTL and testbench

MULTIPLY -- requirements
Module: multiply

---
 rtl/multiply.sv | 88 ++++++++
 tb/tb_multiply.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/multiply.sv
// Sequential shift-and-add multiplier with a signed/unsigned mode.
// Works on operand magnitudes and fixes the sign of the product in a final cycle.
module multiply #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 sign,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 ready,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t              r_state;
    logic [PW-1:0]       r_mcand;
    logic [PW-1:0]       r_acc;
    logic [WIDTH-1:0]    r_mplier;
    logic [CW-1:0]       r_count;
    logic                r_neg;

    logic [WIDTH-1:0]    w_mcand_abs;
    logic [WIDTH-1:0]    w_mplier_abs;

    // Most negative operand negates to itself, which read unsigned is 2^(WIDTH-1).
    assign w_mcand_abs  = (sign && multiplicand[WIDTH-1]) ? (WIDTH'(0) - multiplicand) : multiplicand;
    assign w_mplier_abs = (sign && multiplier[WIDTH-1])   ? (WIDTH'(0) - multiplier)   : multiplier;

    assign ready = (r_state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            r_neg    <= 1'b0;
            product  <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_mcand_abs};
                        r_mplier <= w_mplier_abs;
                        r_acc    <= '0;
                        r_count  <= CW'(WIDTH);
                        r_neg    <= sign & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                        r_state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count - CW'(1);
                    if (r_count == CW'(1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    product <= r_neg ? (PW'(0) - r_acc) : r_acc;
                    done    <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiply.sv
// Directed-vector bench for multiply (WIDTH=32): reset, unsigned, signed,
// corner operands, continuous-start handshake and reset during an operation.
module tb_multiply;

    localparam int W = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            sign;
    logic [W-1:0]    multiplicand;
    logic [W-1:0]    multiplier;
    logic            ready;
    logic            done;
    logic [2*W-1:0]  product;

    int n_vec = 0;
    int n_err = 0;

    multiply #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .sign         (sign),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .ready        (ready),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    // Launch one multiply, scramble operands after acceptance, wait (bounded) for done.
    task automatic do_mult(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [2*W-1:0] p, output int lat,
                           output logic rdy_before, output logic rdy_at_done);
        @(negedge clk);
        sign = s; multiplicand = a; multiplier = b; start = 1'b1;
        rdy_before = ready;
        @(posedge clk); #1;
        start = 1'b0; sign = ~s;
        multiplicand = ~a; multiplier = b ^ 32'h5A5A_A5A5;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
        end
        p = product;
        rdy_at_done = ready;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; sign = 1'b1;
        multiplicand = 32'h1234_5678; multiplier = 32'h9ABC_DEF0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", ready); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        n_vec++; if (product !== 64'h0) begin n_err++; $display("FAIL reset_product: got %h expected 0", product); end
        reset = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL idle_hold_ready: got %b expected 1", ready); end
    endtask

    task automatic test_unsigned;
        logic [W-1:0]   ta [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678};
        logic [W-1:0]   tb [3] = '{32'hFFFF_FFFF, 32'h0000_0007, 32'h0000_0010};
        logic [2*W-1:0] te [3] = '{64'hFFFF_FFFE_0000_0001, 64'h0000_0006_FFFF_FFF9, 64'h0000_0001_2345_6780};
        logic [2*W-1:0] p; int lat; logic rb, rd;
        for (int i = 0; i < 3; i++) begin
            do_mult(1'b0, ta[i], tb[i], p, lat, rb, rd);
            n_vec++; if (rb !== 1'b1) begin n_err++; $display("FAIL unsigned_ready_before[%0d]: got %b expected 1", i, rb); end
            n_vec++; if (p !== te[i]) begin n_err++; $display("FAIL unsigned_product[%0d]: got %h expected %h", i, p, te[i]); end
            n_vec++; if (lat !== W + 1) begin n_err++; $display("FAIL unsigned_latency[%0d]: got %0d expected %0d", i, lat, W + 1); end
            n_vec++; if (rd !== 1'b1) begin n_err++; $display("FAIL unsigned_ready_at_done[%0d]: got %b expected 1", i, rd); end
            @(posedge clk); #1;
            n_vec++; if (done !== 1'b0 || product !== te[i]) begin
                n_err++; $display("FAIL unsigned_after_done[%0d]: got done=%b product=%h expected done=0 product=%h", i, done, product, te[i]);
            end
        end
    endtask

    task automatic test_signed;
        logic [W-1:0]   ta [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
        logic [W-1:0]   tb [4] = '{32'h0000_0007, 32'h0000_0004, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [2*W-1:0] te [4] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF4,
                                   64'hC000_0000_8000_0000, 64'h0000_0000_0000_0001};
        logic [2*W-1:0] p; int lat; logic rb, rd;
        for (int i = 0; i < 4; i++) begin
            do_mult(1'b1, ta[i], tb[i], p, lat, rb, rd);
            n_vec++; if (p !== te[i]) begin n_err++; $display("FAIL signed_product[%0d]: got %h expected %h", i, p, te[i]); end
            n_vec++; if (lat !== W + 1) begin n_err++; $display("FAIL signed_latency[%0d]: got %0d expected %0d", i, lat, W + 1); end
            n_vec++; if (rd !== 1'b1) begin n_err++; $display("FAIL signed_ready_at_done[%0d]: got %b expected 1", i, rd); end
        end
    endtask

    task automatic test_corner;
        logic           ts [3] = '{1'b1, 1'b1, 1'b0};
        logic [W-1:0]   ta [3] = '{32'h8000_0000, 32'hFFFF_FFFB, 32'h0000_0000};
        logic [W-1:0]   tb [3] = '{32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
        logic [2*W-1:0] te [3] = '{64'h4000_0000_0000_0000, 64'h0, 64'h0};
        logic [2*W-1:0] p; int lat; logic rb, rd; int extra;
        for (int i = 0; i < 3; i++) begin
            do_mult(ts[i], ta[i], tb[i], p, lat, rb, rd);
            n_vec++; if (p !== te[i]) begin n_err++; $display("FAIL corner_product[%0d]: got %h expected %h", i, p, te[i]); end
            n_vec++; if (lat !== W + 1) begin n_err++; $display("FAIL corner_latency[%0d]: got %0d expected %0d", i, lat, W + 1); end
            extra = 0;
            repeat (4) begin
                @(posedge clk); #1;
                if (done) extra++;
            end
            n_vec++; if (extra !== 0) begin n_err++; $display("FAIL corner_single_done[%0d]: got %0d extra pulses expected 0", i, extra); end
        end
    endtask

    task automatic test_back_to_back;
        logic [2*W-1:0] q[$];
        logic [2*W-1:0] exp_p;
        logic [2*W-1:0] held = '0;
        int cyc = 0, pulses = 0, last_done = -1;
        sign = 1'b0;
        while (pulses < 3 && cyc < 200) begin
            @(negedge clk);
            if (done) begin
                exp_p = (q.size() > 0) ? q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
                n_vec++; if (product !== exp_p) begin n_err++; $display("FAIL b2b_product[%0d]: got %h expected %h", pulses, product, exp_p); end
                if (last_done >= 0) begin
                    n_vec++; if (cyc - last_done !== W + 2) begin n_err++; $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", pulses, cyc - last_done, W + 2); end
                end
                last_done = cyc; held = product; pulses++;
            end else if (pulses > 0) begin
                n_vec++; if (product !== held) begin n_err++; $display("FAIL b2b_stable@%0d: got %h expected %h", cyc, product, held); end
            end
            multiplicand = 32'(cyc) * 32'h0101_0101 + 32'd1;
            multiplier   = 32'(cyc) + 32'h10;
            start        = 1'b1;
            if (ready) q.push_back(64'(multiplicand) * 64'(multiplier));
            cyc++;
        end
        n_vec++; if (pulses !== 3) begin n_err++; $display("FAIL b2b_timeout: got %0d pulses expected 3", pulses); end
        n_vec++; if (q.size() !== 1) begin n_err++; $display("FAIL b2b_accepted_count: got %0d pending expected 1", q.size()); end
        @(negedge clk); start = 1'b0;
        repeat (W + 4) @(posedge clk);
    endtask

    task automatic test_reset_midop;
        logic [2*W-1:0] p; int lat; logic rb, rd; int seen = 0;
        @(negedge clk);
        sign = 1'b0; multiplicand = 32'd7; multiplier = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL midop_ready: got %b expected 1", ready); end
        n_vec++; if (product !== 64'h0) begin n_err++; $display("FAIL midop_product: got %h expected 0", product); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL midop_done: got %b expected 0", done); end
        repeat (W + 4) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        n_vec++; if (seen !== 0) begin n_err++; $display("FAIL midop_no_done: got %0d pulses expected 0", seen); end
        do_mult(1'b0, 32'd3, 32'd4, p, lat, rb, rd);
        n_vec++; if (p !== 64'd12) begin n_err++; $display("FAIL midop_rerun_product: got %h expected %h", p, 64'd12); end
        n_vec++; if (lat !== W + 1) begin n_err++; $display("FAIL midop_rerun_latency: got %0d expected %0d", lat, W + 1); end
    endtask

    initial begin
        test_reset;
        test_unsigned;
        test_signed;
        test_corner;
        test_back_to_back;
        test_reset_midop;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
